// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling UART receiver. Deframes 8N1 serial data (8E1 when
//            UART_RX_PARITY_EN is defined) from an asynchronous rx pin into
//            bytes held in a one-entry buffer with a valid/read handshake.
//            The oversampling clock is treated as a strobe: its rising edge,
//            detected in the board clock domain, is one sampling tick.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_BITS   payload bits per frame, LSB first (default 8)
//   OVERSAMPLE  ticks per bit period, even and >= 4 (default 16)
// Ports
//   clk_board     in   system clock, all logic on its rising edge
//   reset         in   synchronous, active-high
//   enable        in   low freezes tick detection and the FSM
//   clk_uart_16x  in   oversampling strobe, rising edge = one tick
//   rx            in   asynchronous serial line, idle high
//   data_rd       in   single-cycle pulse, consumer has taken data_out
//   data_out      out  last good byte
//   data_valid    out  data_out holds an unread byte (level)
//   frame_err     out  one-cycle pulse, stop bit sampled low
//   overrun       out  sticky, an unread byte was overwritten
//   parity_err    out  (UART_RX_PARITY_EN only) one-cycle pulse, bad parity
//   busy          out  receiver is not idle
// Configuration macro
//   UART_RX_PARITY_EN  adds an even-parity bit, the PARITY state and the
//                      parity_err port
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_board,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clk_uart_16x,
  input  logic                 rx,
  input  logic                 data_rd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_BIT_W = $clog2(DATA_BITS + 1);

  // Start bit is sampled half a bit period after the falling edge, every
  // later bit a full period after the previous sample point.
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic                   r_rx_meta;
  logic                   r_rx_s;
  logic                   r_tick_q;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bit;
  logic                   r_perr;
`endif

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  logic                   w_tick;
  logic                   w_commit;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic [c_CNT_W-1:0]     w_cnt_inc;
  logic [c_BIT_W-1:0]     w_bit_nxt;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [DATA_BITS-1:0]   w_data_nxt;
  logic                   w_valid_nxt;
  logic                   w_ferr_nxt;
  logic                   w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                   w_par_nxt;
  logic                   w_perr_nxt;
`endif

  // Rising edge of the oversampling strobe. The delayed copy keeps tracking
  // while disabled so re-enabling with the strobe high does not fake a tick.
  assign w_tick    = clk_uart_16x & ~r_tick_q & enable;
  assign w_cnt_inc = r_cnt + c_CNT_W'(1);

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_board) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_tick_q   <= 1'b0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
      r_tick_q   <= clk_uart_16x;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_ferr     <= w_ferr_nxt;
      r_overrun  <= w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= w_par_nxt;
      r_perr     <= w_perr_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data_out;
    w_valid_nxt = r_valid;
    w_ovr_nxt   = r_overrun;
    w_ferr_nxt  = 1'b0;
    w_commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par_bit;
    w_perr_nxt  = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (enable && !r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (w_tick) begin
          if (r_cnt == c_HALF_LAST) begin
            w_cnt_nxt = '0;
            if (r_rx_s) begin
              // Line went back high before mid-bit: treat as a glitch.
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_DATA: begin
        if (w_tick) begin
          if (r_cnt == c_FULL_LAST) begin
            w_cnt_nxt   = '0;
            // Shift right, new bit enters at the MSB: after DATA_BITS samples
            // the first (LSB) bit has reached bit 0.
            w_shift_nxt = DATA_BITS'({r_rx_s, r_shift} >> 1);
            if (r_bit_idx == c_LAST_BIT) begin
              w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit_idx + c_BIT_W'(1);
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          if (r_cnt == c_FULL_LAST) begin
            w_cnt_nxt   = '0;
            w_par_nxt   = r_rx_s;
            w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
`endif

      S_STOP: begin
        if (w_tick) begin
          if (r_cnt == c_FULL_LAST) begin
            w_cnt_nxt = '0;
            if (r_rx_s) begin
              w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero.
              if (^{r_shift, r_par_bit}) begin
                w_perr_nxt = 1'b1;
              end else begin
                w_commit = 1'b1;
              end
`else
              w_commit = 1'b1;
`endif
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_BREAK: begin
        // Hold here until the line recovers so a stuck-low line cannot
        // start a fresh frame on every start-bit check.
        if (enable && r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Read handshake: a read only acts on a buffered byte.
    if (data_rd && r_valid) begin
      w_valid_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end

    // Commit overrides the read; a simultaneous read consumed the old byte,
    // so only an unread byte being replaced counts as overrun.
    if (w_commit) begin
      w_data_nxt  = r_shift;
      w_valid_nxt = 1'b1;
      if (r_valid && !data_rd) begin
        w_ovr_nxt = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx. A strobe rises every
//            4 board clocks (16 ticks = 64 clocks per bit). Frames start on a
//            strobe rising edge so the stop-bit sample lands exactly 33 clocks
//            after the stop bit is driven; outputs are checked 1 ns after the
//            clock edges around that point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk_board = 1'b0;
  logic       reset;
  logic       enable;
  logic       clk_uart_16x;
  logic       rx;
  logic       data_rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [1:0] div;
  logic       pre_valid;
  logic       pre_ferr;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk_board    (clk_board),
    .reset        (reset),
    .enable       (enable),
    .clk_uart_16x (clk_uart_16x),
    .rx           (rx),
    .data_rd      (data_rd),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .overrun      (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk_board = ~clk_board;

  // Oversampling strobe: rising edge every 4 board clocks, 1 ns after an edge.
  initial begin
    div          = 2'd0;
    clk_uart_16x = 1'b0;
    forever begin
      @(posedge clk_board);
      #1;
      div          = div + 2'd1;
      clk_uart_16x = div[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_board);
    #1;
  endtask

  // Drives one frame; returns 1 ns after the clock edge that follows the
  // stop-bit sample tick, with pre_* holding the values one cycle earlier.
  task automatic send_frame(input logic [7:0] d, input logic has_par,
                            input logic par, input logic stop);
    @(posedge clk_uart_16x);
    rx = 1'b0;
    step(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(64);
    end
    if (has_par) begin
      rx = par;
      step(64);
    end
    rx = stop;
    step(32);
    pre_valid = data_valid;
    pre_ferr  = frame_err;
    step(1);
  endtask

  task automatic read_pulse();
    data_rd = 1'b1;
    step(1);
    data_rd = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    rx      = 1'b1;
    data_rd = 1'b0;
    step(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    step(10);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_valid_before", 32'(pre_valid), 32'd0);
    check("a5_valid", 32'(data_valid), 32'd1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_ferr", 32'(frame_err), 32'd0);
    check("a5_busy", 32'(busy), 32'd0);
    step(1);
    check("a5_valid_level", 32'(data_valid), 32'd1);
    read_pulse();
    check("a5_read_valid", 32'(data_valid), 32'd0);

    // Start-bit glitch: low for 3 ticks
    @(posedge clk_uart_16x);
    rx = 1'b0;
    step(12);
    rx = 1'b1;
    step(6);
    check("glitch_busy_high", 32'(busy), 32'd1);
    step(20);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_valid", 32'(data_valid), 32'd0);

    // Framing error on 0x3C
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_before", 32'(pre_ferr), 32'd0);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    check("ferr_valid", 32'(data_valid), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'hA5);
    check("ferr_busy_break", 32'(busy), 32'd1);
    step(1);
    check("ferr_one_cycle", 32'(frame_err), 32'd0);
    step(200);
    check("break_busy_held", 32'(busy), 32'd1);
    check("break_valid", 32'(data_valid), 32'd0);
    rx = 1'b1;
    step(4);
    check("break_exit_busy", 32'(busy), 32'd0);
    step(10);

    // Overrun: 0x11 then 0x22 unread
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    check("b11_data", 32'(data_out), 32'h11);
    check("b11_overrun", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("b22_valid_before", 32'(pre_valid), 32'd1);
    check("b22_data", 32'(data_out), 32'h22);
    check("b22_valid", 32'(data_valid), 32'd1);
    check("b22_overrun", 32'(overrun), 32'd1);
    read_pulse();
    check("ovr_read_valid", 32'(data_valid), 32'd0);
    check("ovr_read_overrun", 32'(overrun), 32'd0);
    step(10);

    // Reset during bit 4 of 0xFF
    @(posedge clk_uart_16x);
    rx = 1'b0;
    step(64);
    rx = 1'b1;
    step(64 * 4 + 30);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step(1);
    check("mid_rst_data", 32'(data_out), 32'h00);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    step(400);
    check("post_rst_valid", 32'(data_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("b5a_data", 32'(data_out), 32'h5A);
    check("b5a_valid", 32'(data_valid), 32'd1);
    check("b5a_overrun", 32'(overrun), 32'd0);
    check("b5a_ferr", 32'(frame_err), 32'd0);

`ifdef UART_RX_PARITY_EN
    read_pulse();
    step(10);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check("par_bad_pulse", 32'(parity_err), 32'd1);
    check("par_bad_valid", 32'(data_valid), 32'd0);
    check("par_bad_data", 32'(data_out), 32'h5A);
    step(1);
    check("par_bad_one_cycle", 32'(parity_err), 32'd0);
    step(10);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_ok_data", 32'(data_out), 32'h07);
    check("par_ok_valid", 32'(data_valid), 32'd1);
    check("par_ok_perr", 32'(parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
